// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage types and constants.
package instr_fetch_pkg;

    // One queued instruction with the PC it was fetched from; decode consumes these.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Free entries needed before a new request: one request in flight plus one
    // being issued can each push two words.
    localparam int unsigned FETCH_CREDIT = 4;

    // Start of the next 8-byte cache line after pc, wrapping at 2^32.
    function automatic logic [31:0] next_line(input logic [31:0] pc);
        return {pc[31:3], 3'b000} + 32'd8;
    endfunction

endpackage

// File: rtl/cpu_ibus_if.sv
// Instruction-cache bus between fetch (master) and icache (slave).
interface cpu_ibus_if;
    logic        read;
    logic [31:0] address;
    logic        flush_1;
    logic        flush_2;
    logic        stall;
    logic        valid;
    logic [63:0] rddata;

    modport master (
        output read, address, flush_1, flush_2,
        input  stall, valid, rddata
    );

    modport slave (
        input  read, address, flush_1, flush_2,
        output stall, valid, rddata
    );
endinterface

// File: rtl/instr_queue.sv
// Dual-push / dual-pop circular FIFO. DEPTH must be a power of two so the
// pointers wrap by simple overflow.
module instr_queue #(
    parameter int unsigned DEPTH = 8,
    parameter type         dtype = logic [63:0]
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               push_n,
    input  dtype                     push_data [2],
    input  logic [1:0]               pop_n,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output dtype                     head_data [2]
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    dtype          mem [DEPTH];

    // Storage writes at tail and tail+1; contents need no reset since count gates use.
    always_ff @(posedge clk) begin
        if (!flush && push_n != 2'd0) mem[tail] <= push_data[0];
        if (!flush && push_n == 2'd2) mem[tail + PW'(1)] <= push_data[1];
    end

    // Pointer and occupancy update; flush discards everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop_n);
            tail  <= tail + PW'(push_n);
            count <= count + CW'(push_n) - CW'(pop_n);
        end
    end

    assign head_data[0] = mem[head];
    assign head_data[1] = mem[head + PW'(1)];

    // The upstream credit rule must keep occupancy within DEPTH.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !flush |-> (int'(count) + int'(push_n) <= int'(DEPTH) + int'(pop_n)));

    // Consumers may only take what is present.
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !flush |-> (int'(pop_n) <= int'(count)));

endmodule

// File: rtl/instr_fetch.sv
// Fetch front end: PC generation (F1), icache response capture (F2) and
// instruction queue feeding decode.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'hbfc0_0000,
    parameter int unsigned QUEUE_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    cpu_ibus_if.master       ibus,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [1:0]       instr_valid,
    output logic [1:0][31:0] instr,
    output logic [1:0][31:0] instr_pc,
    input  logic [1:0]       pop_cnt
);
    localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

    logic [31:0]  pc;
    logic [31:0]  s2_pc;
    logic         s2_valid;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic [1:0]   push_n;
    logic [1:0]   pop_n;
    fetch_entry_t push_data [2];
    fetch_entry_t head_data [2];

    // Request only with enough room for everything that could still land;
    // a redirect kills the request and flushes both cache stages.
    always_comb begin
        free          = CW'(QUEUE_DEPTH) - count;
        ibus.read     = (free >= CW'(FETCH_CREDIT)) && !redirect_valid;
        ibus.address  = pc;
        ibus.flush_1  = redirect_valid;
        ibus.flush_2  = redirect_valid;
    end

    // F1 PC and F2 request metadata; everything holds while the cache stalls,
    // except a redirect which always wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            s2_valid <= 1'b0;
            s2_pc    <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            s2_valid <= 1'b0;
        end else if (!ibus.stall) begin
            s2_valid <= ibus.read;
            if (ibus.read) begin
                pc    <= next_line(pc);
                s2_pc <= pc;
            end
        end
    end

    // F2 response split: an odd-word PC only keeps the upper half of the line.
    always_comb begin
        push_n             = 2'd0;
        push_data[0].instr = s2_pc[2] ? ibus.rddata[63:32] : ibus.rddata[31:0];
        push_data[0].pc    = s2_pc;
        push_data[1].instr = ibus.rddata[63:32];
        push_data[1].pc    = s2_pc + 32'd4;
        if (ibus.valid && s2_valid && !redirect_valid)
            push_n = s2_pc[2] ? 2'd1 : 2'd2;
        pop_n = redirect_valid ? 2'd0 : pop_cnt;
    end

    instr_queue #(
        .DEPTH (QUEUE_DEPTH),
        .dtype (fetch_entry_t)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push_n    (push_n),
        .push_data (push_data),
        .pop_n     (pop_n),
        .flush     (redirect_valid),
        .count     (count),
        .head_data (head_data)
    );

    // Decode view: driven from registered queue state only, zeroed when empty.
    always_comb begin
        instr_valid = {count > CW'(1), count > CW'(0)};
        for (int k = 0; k < 2; k++) begin
            instr[k]    = instr_valid[k] ? head_data[k].instr : 32'd0;
            instr_pc[k] = instr_valid[k] ? head_data[k].pc    : 32'd0;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: icache/decoder models plus a queue-level reference.
module tb_instr_fetch;
    localparam logic [31:0] RPC = 32'hbfc0_0000;
    localparam int          QD  = 8;
    localparam int          MISS_LEN = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             redirect_valid = 1'b0;
    logic [31:0]      redirect_pc = '0;
    logic [1:0]       pop_cnt = '0;
    logic [1:0]       instr_valid;
    logic [1:0][31:0] instr;
    logic [1:0][31:0] instr_pc;

    cpu_ibus_if ibus();

    instr_fetch #(.RESET_PC(RPC), .QUEUE_DEPTH(QD)) dut (
        .clk            (clk),
        .rst            (rst),
        .ibus           (ibus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .pop_cnt        (pop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stimulus knobs
    int   pop_want = 2;
    bit   miss_arm = 1'b0;
    bit   use_const = 1'b1;

    // Memory image: either the fixed test pattern or an address-derived word.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (use_const) return a[2] ? 32'h2222_2222 : 32'h1111_1111;
        return a ^ 32'h5A5A_0000;
    endfunction

    // Reference model: queue of {instr, pc}, the PC the DUT should present,
    // and the PC of the request the cache is answering.
    logic [63:0] mq[$];
    logic [31:0] m_pc = RPC;
    logic [31:0] m_s2_pc = '0;

    // Values sampled mid-cycle for the cache model
    bit          cap_acc = 1'b0;
    bit          cap_flush = 1'b0;
    logic [31:0] cap_addr = '0;

    // Cache + decoder model: one-cycle hit, optional miss, drain after aborted miss.
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          miss_left = 0;
    int          drain = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend = 1'b0; miss_left = 0; drain = 0;
            ibus.stall = 1'b0; ibus.valid = 1'b0; ibus.rddata = '0;
            pop_cnt = 2'd0;
        end else begin
            #1;
            if (cap_flush) begin
                drain = (pend && miss_left > 0) ? 3 : 0;
                pend = 1'b0;
                miss_left = 0;
            end else begin
                if (ibus.valid) pend = 1'b0;
                if (cap_acc) begin
                    pend = 1'b1;
                    pend_addr = cap_addr;
                    miss_left = miss_arm ? MISS_LEN : 0;
                end
            end
            if (drain > 0) begin
                ibus.stall = 1'b1; ibus.valid = 1'b0; drain--;
            end else if (pend && miss_left > 0) begin
                ibus.stall = 1'b1; ibus.valid = 1'b0; miss_left--;
            end else if (pend) begin
                ibus.stall = 1'b0; ibus.valid = 1'b1;
                ibus.rddata = {word_at({pend_addr[31:3], 3'b100}), word_at({pend_addr[31:3], 3'b000})};
            end else begin
                ibus.stall = 1'b0; ibus.valid = 1'b0;
            end
            pop_cnt = 2'((mq.size() < pop_want) ? mq.size() : pop_want);
        end
    end

    // Compare DUT against the model each cycle, then advance the model to the next edge.
    always @(negedge clk) begin
        logic [63:0] e;
        bit          e_read;
        cap_acc   = ibus.read && !ibus.stall;
        cap_addr  = ibus.address;
        cap_flush = ibus.flush_1;
        if (rst) begin
            mq.delete();
            m_pc = RPC;
            chk("rst_instr_valid", 64'(instr_valid), 64'd0);
            chk("rst_instr0", 64'(instr[0]), 64'd0);
            chk("rst_instr_pc0", 64'(instr_pc[0]), 64'd0);
            chk("rst_flush", 64'({ibus.flush_1, ibus.flush_2}), 64'd0);
        end else begin
            e_read = (QD - mq.size() >= 4) && !redirect_valid;
            chk("read", 64'(ibus.read), 64'(e_read));
            chk("address", 64'(ibus.address), 64'(m_pc));
            chk("flush", 64'({ibus.flush_1, ibus.flush_2}), {62'd0, redirect_valid, redirect_valid});
            chk("instr_valid", 64'(instr_valid), {62'd0, mq.size() > 1, mq.size() > 0});
            for (int k = 0; k < 2; k++) begin
                e = (mq.size() > k) ? mq[k] : 64'd0;
                chk($sformatf("instr%0d", k), 64'(instr[k]), 64'(e[63:32]));
                chk($sformatf("instr_pc%0d", k), 64'(instr_pc[k]), 64'(e[31:0]));
            end
            if (redirect_valid) begin
                mq.delete();
                m_pc = redirect_pc;
            end else begin
                for (int k = 0; k < int'(pop_cnt); k++)
                    if (mq.size() > 0) void'(mq.pop_front());
                if (ibus.valid) begin
                    mq.push_back({word_at(m_s2_pc), m_s2_pc});
                    if (!m_s2_pc[2])
                        mq.push_back({word_at(m_s2_pc + 32'd4), m_s2_pc + 32'd4});
                end
                if (e_read && !ibus.stall) begin
                    m_s2_pc = m_pc;
                    m_pc = {m_pc[31:3], 3'b000} + 32'd8;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset release with constant-pattern hit cache
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t1_read", 64'(ibus.read), 64'd1);
        chk("t1_addr", 64'(ibus.address), 64'(RPC));
        chk("t1_valid", 64'(instr_valid), 64'd0);
        cyc(2); #1;
        chk("t1_c3_valid", 64'(instr_valid), 64'd3);
        chk("t1_c3_pc0", 64'(instr_pc[0]), 64'hbfc0_0000);
        chk("t1_c3_pc1", 64'(instr_pc[1]), 64'hbfc0_0004);
        chk("t1_c3_i0", 64'(instr[0]), 64'h1111_1111);
        chk("t1_c3_i1", 64'(instr[1]), 64'h2222_2222);
        cyc(1); #1;
        chk("t1_c4_pc0", 64'(instr_pc[0]), 64'hbfc0_0008);
        chk("t1_c4_valid", 64'(instr_valid), 64'd3);
        cyc(4);

        // Redirect to odd-word PC with decoder stalled: fills the queue
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0014; pop_want = 0; use_const = 1'b0;
        #1;
        chk("t2_flush", 64'(ibus.flush_1), 64'd1);
        chk("t2_read_off", 64'(ibus.read), 64'd0);
        cyc(1); redirect_valid = 1'b0; #1;
        chk("t2_addr", 64'(ibus.address), 64'h8000_0014);
        chk("t2_valid0", 64'(instr_valid), 64'd0);
        chk("t2_flush_off", 64'(ibus.flush_1), 64'd0);
        cyc(1); #1;
        chk("t2_next_addr", 64'(ibus.address), 64'h8000_0018);
        cyc(1); #1;
        chk("t2_single", 64'(instr_valid), 64'd1);
        chk("t2_pc0", 64'(instr_pc[0]), 64'h8000_0014);
        chk("t2_i0", 64'(instr[0]), 64'hda5a_0014);
        cyc(3); #1;
        chk("t3_read_drop", 64'(ibus.read), 64'd0);
        cyc(5); #1;
        chk("t3_read_held", 64'(ibus.read), 64'd0);
        chk("t3_pc0", 64'(instr_pc[0]), 64'h8000_0014);
        pop_want = 2;
        cyc(4); #1;
        chk("t3_resume", 64'(ibus.read), 64'd1);
        cyc(6);

        // Ten-cycle miss, redirected while stalled
        miss_arm = 1'b1;
        cyc(1); miss_arm = 1'b0;
        cyc(4);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
        #1;
        chk("t4_flush1", 64'(ibus.flush_1), 64'd1);
        chk("t4_flush2", 64'(ibus.flush_2), 64'd1);
        cyc(1); redirect_valid = 1'b0; #1;
        chk("t4_flush_once", 64'({ibus.flush_1, ibus.flush_2}), 64'd0);
        chk("t4_empty", 64'(instr_valid), 64'd0);
        cyc(5); #1;
        chk("t4_first_pc", 64'(instr_pc[0]), 64'h0000_1000);
        chk("t4_first_i", 64'(instr[0]), 64'h5a5a_1000);
        cyc(6); #1;

        // Redirect coincident with a response and a two-instruction pop
        chk("t5_pre_valid", 64'(instr_valid), 64'd3);
        chk("t5_pre_ibus_valid", 64'(ibus.valid), 64'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
        cyc(1); redirect_valid = 1'b0; #1;
        chk("t5_empty", 64'(instr_valid), 64'd0);
        cyc(6);

        // Asynchronous reset mid-burst
        #1 rst = 1'b1;
        #1;
        chk("t6_valid", 64'(instr_valid), 64'd0);
        chk("t6_instr", 64'(instr), 64'd0);
        chk("t6_pc", 64'(instr_pc), 64'd0);
        chk("t6_flush", 64'(ibus.flush_1), 64'd0);
        cyc(2); rst = 1'b0; #1;
        chk("t6_read", 64'(ibus.read), 64'd1);
        chk("t6_addr", 64'(ibus.address), 64'(RPC));
        cyc(2); #1;
        chk("t6_c3_valid", 64'(instr_valid), 64'd3);
        chk("t6_c3_pc1", 64'(instr_pc[1]), 64'hbfc0_0004);
        chk("t6_c3_i0", 64'(instr[0]), 64'he59a_0000);
        cyc(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
